// File: rtl/mem_access_unit.sv
// MEM stage: req/gnt/rvalid data-memory handshake with sized loads/stores,
// misalign/illegal-op detection and a response timeout.
module mem_access_unit #(
    parameter int XLEN        = 32,
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [2:0]        funct3,
    input  logic              forward_mem,
    input  logic [XLEN-1:0]   prior_mem_data,
    input  logic [ADDR_W-1:0] alu_result,
    input  logic [XLEN-1:0]   rs2,
    output logic              stall,
    output logic [XLEN-1:0]   rd_data,
    output logic              rd_valid,
    output logic              misaligned,
    output logic              bus_err,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [XLEN/8-1:0] dmem_be,
    output logic [XLEN-1:0]   dmem_wdata,
    input  logic              dmem_gnt,
    input  logic              dmem_rvalid,
    input  logic [XLEN-1:0]   dmem_rdata
);

    localparam int NB   = XLEN / 8;
    localparam int OFFW = $clog2(NB);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;
    state_t state, state_nx;

    logic [OFFW-1:0]   off_in, off_q, align_mask;
    logic [NB-1:0]     size_mask, be_in;
    logic [XLEN-1:0]   st_src, wdata_in, lane, ld_ext;
    logic              one_op, f3_legal, is_misal, accept, drop_ill, drop_mis;
    logic [ADDR_W-1:0] addr_q;
    logic [2:0]        f3_q;
    logic [31:0]       tcnt;
    logic              tmo, tmo_fire, done_st, done_ld;

    // Shift the field to the top, then shift back logically or arithmetically.
    function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] v,
                                               input int unsigned bits,
                                               input logic uns);
        logic [XLEN-1:0] sh;
        sh = v << (XLEN - bits);
        if (uns) return sh >> (XLEN - bits);
        return XLEN'($signed(sh) >>> (XLEN - bits));
    endfunction

    always_comb begin
        one_op   = mem_read ^ mem_write;
        f3_legal = 1'b0;
        case (funct3)
            3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
            3'b011:                 f3_legal = (XLEN == 64);
            3'b100, 3'b101:         f3_legal = mem_read;
            3'b110:                 f3_legal = mem_read && (XLEN == 64);
            default:                f3_legal = 1'b0;
        endcase
        off_in     = alu_result[OFFW-1:0];
        align_mask = OFFW'((32'd1 << funct3[1:0]) - 32'd1);
        is_misal   = (off_in & align_mask) != '0;
        case (funct3[1:0])
            2'd0:    size_mask = NB'(1);
            2'd1:    size_mask = NB'(3);
            2'd2:    size_mask = NB'(15);
            default: size_mask = '1;
        endcase
        be_in  = size_mask << off_in;
        st_src = forward_mem ? prior_mem_data : rs2;
        case (funct3[1:0])
            2'd0:    wdata_in = {NB{st_src[7:0]}};
            2'd1:    wdata_in = {(NB/2){st_src[15:0]}};
            2'd2:    wdata_in = {(NB/4){st_src[31:0]}};
            default: wdata_in = st_src;
        endcase
        accept   = (state == S_IDLE) && in_valid && one_op && f3_legal && !is_misal;
        drop_ill = (state == S_IDLE) && in_valid &&
                   ((mem_read && mem_write) || (one_op && !f3_legal));
        drop_mis = (state == S_IDLE) && in_valid && one_op && f3_legal && is_misal;
    end

    always_comb begin
        lane     = dmem_rdata >> {off_q, 3'b000};
        ld_ext   = extend(lane, 32'd8 << f3_q[1:0], f3_q[2]);
        tmo      = (TIMEOUT_CYC != 0) && (tcnt >= 32'(TIMEOUT_CYC - 1));
        done_st  = (state == S_REQ) && dmem_gnt && dmem_we;
        done_ld  = (state == S_WAIT) && dmem_rvalid;
        // A response arriving in the final allowed cycle wins over the timeout.
        tmo_fire = tmo && (((state == S_REQ) && !dmem_gnt) ||
                           ((state == S_WAIT) && !dmem_rvalid));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (accept) state_nx = S_REQ;
            S_REQ: begin
                if (dmem_gnt)      state_nx = dmem_we ? S_IDLE : S_WAIT;
                else if (tmo_fire) state_nx = S_IDLE;
            end
            S_WAIT: if (dmem_rvalid || tmo_fire) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        stall    = (state != S_IDLE) || accept;
        dmem_req = (state == S_REQ);
    end

    assign off_q     = addr_q[OFFW-1:0];
    assign dmem_addr = {addr_q[ADDR_W-1:OFFW], {OFFW{1'b0}}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q     <= '0;
            f3_q       <= '0;
            dmem_we    <= 1'b0;
            dmem_be    <= '0;
            dmem_wdata <= '0;
            rd_data    <= '0;
            rd_valid   <= 1'b0;
            misaligned <= 1'b0;
            bus_err    <= 1'b0;
            tcnt       <= '0;
        end else begin
            rd_valid   <= done_st || done_ld;
            misaligned <= drop_mis;
            bus_err    <= drop_ill || tmo_fire;
            if (accept) begin
                addr_q     <= alu_result;
                f3_q       <= funct3;
                dmem_we    <= mem_write;
                dmem_be    <= be_in;
                dmem_wdata <= wdata_in;
            end
            if (done_ld)       rd_data <= ld_ext;
            else if (tmo_fire) rd_data <= '0;
            if (state_nx == S_IDLE)  tcnt <= '0;
            else if (state != S_IDLE) tcnt <= tcnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: scoreboard of expected responses,
// plus a second instance with a short timeout.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, mem_read, mem_write, forward_mem;
    logic [2:0]  funct3;
    logic [31:0] prior_mem_data, alu_result, rs2;
    logic        dmem_gnt, dmem_rvalid;
    logic [31:0] dmem_rdata;

    logic        stall, rd_valid, misaligned, bus_err, dmem_req, dmem_we;
    logic [31:0] rd_data, dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;

    logic        t_stall, t_rd_valid, t_misaligned, t_bus_err, t_dmem_req, t_dmem_we;
    logic [31:0] t_rd_data, t_dmem_addr, t_dmem_wdata;
    logic [3:0]  t_dmem_be;

    localparam logic [2:0] K_RDV = 3'b001;
    localparam logic [2:0] K_MIS = 3'b010;
    localparam logic [2:0] K_ERR = 3'b100;

    typedef struct {
        logic [2:0]  kind;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];

    int tests = 0;
    int fails = 0;

    int          sc;
    logic [3:0]  be;
    logic [31:0] wd;
    logic        we;

    always #5 clk = ~clk;

    mem_access_unit #(.XLEN(32), .ADDR_W(32), .TIMEOUT_CYC(64)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .mem_read(mem_read),
        .mem_write(mem_write), .funct3(funct3), .forward_mem(forward_mem),
        .prior_mem_data(prior_mem_data), .alu_result(alu_result), .rs2(rs2),
        .stall(stall), .rd_data(rd_data), .rd_valid(rd_valid),
        .misaligned(misaligned), .bus_err(bus_err), .dmem_req(dmem_req),
        .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
        .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
        .dmem_rdata(dmem_rdata)
    );

    mem_access_unit #(.XLEN(32), .ADDR_W(32), .TIMEOUT_CYC(4)) dut_to (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .mem_read(mem_read),
        .mem_write(mem_write), .funct3(funct3), .forward_mem(forward_mem),
        .prior_mem_data(prior_mem_data), .alu_result(alu_result), .rs2(rs2),
        .stall(t_stall), .rd_data(t_rd_data), .rd_valid(t_rd_valid),
        .misaligned(t_misaligned), .bus_err(t_bus_err), .dmem_req(t_dmem_req),
        .dmem_we(t_dmem_we), .dmem_addr(t_dmem_addr), .dmem_be(t_dmem_be),
        .dmem_wdata(t_dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
        .dmem_rdata(dmem_rdata)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [2:0] k, input logic [31:0] d);
        exp_t e;
        e.kind = k;
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic expect_out(input string tag, input int budget);
        exp_t e;
        int   n;
        logic seen;
        n = 0;
        while (!(rd_valid || misaligned || bus_err) && n < budget) begin
            @(negedge clk); #1; n++;
        end
        seen = rd_valid || misaligned || bus_err;
        chk({tag, "_resp"}, seen, 1);
        if (sb.size() == 0) begin
            chk({tag, "_sb"}, 0, 1);
        end else begin
            e = sb.pop_front();
            if (seen) begin
                chk({tag, "_kind"}, {bus_err, misaligned, rd_valid}, e.kind);
                chk({tag, "_data"}, rd_data, e.data);
            end
        end
    endtask

    task automatic xact(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic fwd, input logic [31:0] prior,
                        input logic [31:0] addr, input logic [31:0] sdata,
                        input logic [31:0] rdata, input int gnt_delay,
                        input int rv_delay, output int stall_cyc,
                        output logic [3:0] be_o, output logic [31:0] wdata_o,
                        output logic we_o);
        stall_cyc = 0;
        in_valid = 1'b1; mem_read = rd; mem_write = wr; funct3 = f3;
        forward_mem = fwd; prior_mem_data = prior; alu_result = addr; rs2 = sdata;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
        #1 stall_cyc += stall ? 1 : 0;
        @(negedge clk);
        in_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        for (int i = 0; i < gnt_delay; i++) begin
            #1;
            chk("req_held", dmem_req, 1);
            chk("addr_held", dmem_addr, addr & ~32'h3);
            stall_cyc += stall ? 1 : 0;
            @(negedge clk);
        end
        dmem_gnt = 1'b1;
        #1;
        chk("req", dmem_req, 1);
        be_o = dmem_be; wdata_o = dmem_wdata; we_o = dmem_we;
        stall_cyc += stall ? 1 : 0;
        @(negedge clk);
        dmem_gnt = 1'b0;
        if (rd) begin
            for (int i = 1; i < rv_delay; i++) begin
                #1 stall_cyc += stall ? 1 : 0;
                @(negedge clk);
            end
            dmem_rvalid = 1'b1; dmem_rdata = rdata;
            #1 stall_cyc += stall ? 1 : 0;
            @(negedge clk);
            dmem_rvalid = 1'b0; dmem_rdata = '0;
        end
        #1 chk("stall_released", stall, 0);
    endtask

    task automatic drop(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] addr);
        in_valid = 1'b1; mem_read = rd; mem_write = wr; funct3 = f3; alu_result = addr;
        #1 chk("drop_nostall", stall, 0);
        @(negedge clk);
        in_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        #1;
        chk("drop_noreq", dmem_req, 0);
        chk("drop_stall", stall, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        funct3 = '0; forward_mem = 1'b0; prior_mem_data = '0; alu_result = '0;
        rs2 = '0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
        @(negedge clk); #1;
        chk("rst_stall", stall, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_pulses", {rd_valid, misaligned, bus_err}, 0);
        chk("rst_req", dmem_req, 0);
        chk("rst_be", dmem_be, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // SW 0xDEADBEEF @0x100, immediate grant
        push(K_RDV, 32'h0);
        xact(1'b0, 1'b1, 3'b010, 1'b0, 32'h0, 32'h100, 32'hDEADBEEF, 32'h0, 0, 0, sc, be, wd, we);
        chk("sw_be", be, 4'hF);
        chk("sw_wdata", wd, 32'hDEADBEEF);
        chk("sw_we", we, 1);
        chk("sw_stall", sc, 2);
        expect_out("sw", 0);

        // LB / LBU @0x103
        push(K_RDV, 32'hFFFFFF80);
        xact(1'b1, 1'b0, 3'b000, 1'b0, 32'h0, 32'h103, 32'h0, 32'h80FF0000, 0, 1, sc, be, wd, we);
        chk("lb_be", be, 4'h8);
        chk("lb_we", we, 0);
        chk("lb_stall", sc, 3);
        expect_out("lb", 0);
        push(K_RDV, 32'h00000080);
        xact(1'b1, 1'b0, 3'b100, 1'b0, 32'h0, 32'h103, 32'h0, 32'h80FF0000, 0, 1, sc, be, wd, we);
        expect_out("lbu", 0);

        // SH with forwarded data
        push(K_RDV, 32'h00000080);
        xact(1'b0, 1'b1, 3'b001, 1'b1, 32'hABCD5678, 32'h102, 32'h1234, 32'h0, 0, 0, sc, be, wd, we);
        chk("sh_be", be, 4'hC);
        chk("sh_wdata", wd, 32'h56785678);
        chk("sh_stall", sc, 2);
        expect_out("sh", 0);

        // Dropped accesses
        push(K_MIS, 32'h00000080);
        drop(1'b1, 1'b0, 3'b010, 32'h102);
        expect_out("lw_mis", 0);
        push(K_ERR, 32'h00000080);
        drop(1'b1, 1'b0, 3'b011, 32'h100);
        expect_out("ld32_ill", 0);
        push(K_ERR, 32'h00000080);
        drop(1'b1, 1'b1, 3'b010, 32'h100);
        expect_out("rw_ill", 0);
        push(K_ERR, 32'h00000080);
        drop(1'b0, 1'b1, 3'b100, 32'h100);
        expect_out("st_f3_ill", 0);

        // LH with slow grant and slow response
        push(K_RDV, 32'hFFFF8001);
        xact(1'b1, 1'b0, 3'b001, 1'b0, 32'h0, 32'h206, 32'h0, 32'h80010000, 3, 2, sc, be, wd, we);
        chk("lh_slow_be", be, 4'hC);
        chk("lh_slow_stall", sc, 7);
        expect_out("lh_slow", 0);
        push(K_RDV, 32'h0000F00D);
        xact(1'b1, 1'b0, 3'b101, 1'b0, 32'h0, 32'h200, 32'h0, 32'h0000F00D, 0, 1, sc, be, wd, we);
        chk("lhu_stall", sc, 3);
        expect_out("lhu", 0);
        push(K_RDV, 32'h12345678);
        xact(1'b1, 1'b0, 3'b010, 1'b0, 32'h0, 32'h204, 32'h0, 32'h12345678, 0, 1, sc, be, wd, we);
        expect_out("lw", 0);
        chk("to_pre", t_rd_data, 32'h12345678);

        // Timeout on the short-timeout instance; main instance keeps waiting
        in_valid = 1'b1; mem_read = 1'b1; funct3 = 3'b010; alu_result = 32'h300;
        @(negedge clk);
        in_valid = 1'b0; mem_read = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("to_req", t_dmem_req, 1);
            chk("to_noerr", t_bus_err, 0);
            @(negedge clk);
        end
        #1;
        chk("to_err", t_bus_err, 1);
        chk("to_rd_zero", t_rd_data, 0);
        chk("to_req_drop", t_dmem_req, 0);
        chk("to_stall", t_stall, 0);
        chk("main_noerr", bus_err, 0);
        chk("main_req", dmem_req, 1);

        // Main instance into WAIT, then async reset
        dmem_gnt = 1'b1;
        @(negedge clk);
        dmem_gnt = 1'b0;
        #1;
        chk("wait_stall", stall, 1);
        chk("wait_noreq", dmem_req, 0);
        rst_n = 1'b0;
        #1;
        chk("arst_req", dmem_req, 0);
        chk("arst_stall", stall, 0);
        chk("arst_rd", rd_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        dmem_rvalid = 1'b1; dmem_rdata = 32'hFFFFFFFF;
        @(negedge clk);
        dmem_rvalid = 1'b0; dmem_rdata = '0;
        #1;
        chk("stray_rv", rd_valid, 0);
        chk("stray_rd", rd_data, 0);
        chk("stray_rv_to", t_rd_valid, 0);

        // Recovery: SB @0x101
        push(K_RDV, 32'h0);
        xact(1'b0, 1'b1, 3'b000, 1'b0, 32'h0, 32'h101, 32'h000000A5, 32'h0, 0, 0, sc, be, wd, we);
        chk("sb_be", be, 4'h2);
        chk("sb_wdata", wd, 32'hA5A5A5A5);
        chk("sb_stall", sc, 2);
        expect_out("sb", 0);

        chk("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
